// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU: ADD/SUB/AND/ORR/EOR/LSL/LSR plus an iterative shift-add MUL,
// with valid/ready handshakes on both sides. Define ALU_MUL_EN to build the multiplier.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             Carry
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = ShW + 1;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOrr = 3'b011;
  localparam logic [2:0] OpEor = 3'b100;
  localparam logic [2:0] OpLsl = 3'b101;
  localparam logic [2:0] OpLsr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_multicycle: WIDTH must be a power of two and at least 4");
  end

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e state_q, state_d;

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_res;
  logic             load_v;
  logic             load_c;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, neg_q, ovf_q, carry_q;

  // Single-cycle datapath, evaluated on the operands presented at acceptance
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             alu_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [ShW-1:0]   sh_amt;

  assign sh_amt = SrcB[ShW-1:0];

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    sum     = '0;
    shl     = '0;
    shr     = '0;
    case (ALUControl)
      OpAdd: begin
        sum     = {1'b0, SrcA} + {1'b0, SrcB};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OpSub: begin
        sum     = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OpAnd: alu_res = SrcA & SrcB;
      OpOrr: alu_res = SrcA | SrcB;
      OpEor: alu_res = SrcA ^ SrcB;
      OpLsl: begin
        // The extra top bit catches the last bit shifted out; stays 0 for a zero shift
        shl     = {1'b0, SrcA} << sh_amt;
        alu_res = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      OpLsr: begin
        shr     = {SrcA, 1'b0} >> sh_amt;
        alu_res = shr[WIDTH:1];
        alu_c   = shr[0];
      end
      OpMul: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  assign InReady = (state_q == StIdle) && (!out_valid_q || OutReady);
  assign accept  = InValid && InReady;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;

  // Count 0 is the capture cycle; counts 1..WIDTH each perform one shift-add step
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (state_q == StIdle && accept && ALUControl == OpMul) begin
      mcand_q  <= {{WIDTH{1'b0}}, SrcA};
      mplier_q <= SrcB;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == StMul) begin
      cnt_q <= cnt_q + CntW'(1);
      if (cnt_q != '0) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_res = alu_res;
    load_v   = alu_v;
    load_c   = alu_c;
    case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (ALUControl == OpMul) begin
            state_d = StMul;
          end else begin
            load = 1'b1;
          end
`else
          load = 1'b1;
`endif
        end
      end
`ifdef ALU_MUL_EN
      StMul: begin
        if (cnt_q == CntW'(WIDTH)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        load_res = acc_q[WIDTH-1:0];
        load_v   = |acc_q[2*WIDTH-1:WIDTH];
        load_c   = 1'b0;
        if (!out_valid_q || OutReady) begin
          load    = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // One-entry output register; a same-edge load wins over a pop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      result_q    <= load_res;
      zero_q      <= (load_res == '0);
      neg_q       <= load_res[WIDTH-1];
      ovf_q       <= load_v;
      carry_q     <= load_c;
    end else if (out_valid_q && OutReady) begin
      out_valid_q <= 1'b0;
    end
  end

  assign OutValid  = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Overflow  = ovf_q;
  assign Carry     = carry_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus a randomized scoreboard run.
// Expectations for MUL follow ALU_MUL_EN as defined for the build.
module tb_alu_multicycle;

  localparam int W = 32;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOrr = 3'b011;
  localparam logic [2:0] OpEor = 3'b100;
  localparam logic [2:0] OpLsl = 3'b101;
  localparam logic [2:0] OpLsr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  logic         clk;
  logic         reset_n;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [2:0]   ALUControl;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] ALUResult;
  logic         Zero, Negative, Overflow, Carry;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .InValid   (InValid),
    .InReady   (InReady),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUControl(ALUControl),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .Negative  (Negative),
    .Overflow  (Overflow),
    .Carry     (Carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {OutValid, ALUResult, Z, N, V, C}
  function automatic logic [36:0] outs();
    return {OutValid, ALUResult, Zero, Negative, Overflow, Carry};
  endfunction

  // Reference: {result, Z, N, V, C} from plain integer arithmetic
  function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0]     r;
    logic            v, c;
    logic [63:0]     wide;
    longint          s;
    int              sh;
    sh = int'(b[4:0]);
    r = '0; v = 1'b0; c = 1'b0;
    case (op)
      OpAdd: begin
        wide = 64'(a) + 64'(b);
        r = wide[31:0];
        c = wide > 64'hFFFF_FFFF;
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OpSub: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OpAnd: r = a & b;
      OpOrr: r = a | b;
      OpEor: r = a ^ b;
      OpLsl: begin
        r = a << sh;
        c = (sh == 0) ? 1'b0 : a[32-sh];
      end
      OpLsr: begin
        r = a >> sh;
        c = (sh == 0) ? 1'b0 : a[sh-1];
      end
      default: begin
`ifdef ALU_MUL_EN
        wide = 64'(a) * 64'(b);
        r = wide[31:0];
        v = (wide[63:32] != 0);
`else
        r = '0;
`endif
      end
    endcase
    return {r, (r == 0), r[31], v, c};
  endfunction

  // Present one op, expect acceptance this cycle and the given result on the next edge
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
    ALUControl = op; SrcA = a; SrcB = b; InValid = 1'b1;
    #1;
    check({tag, "_rdy"}, 64'(InReady), 64'd1);
    @(posedge clk); #1;
    check(tag, 64'(outs()), 64'({1'b1, er, ef}));
  endtask

  logic [35:0] q[$];
  logic [35:0] exp_add;
  logic        acc, pop, ok;
  int          n;

  initial begin
    reset_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    SrcA = '0; SrcB = '0; ALUControl = OpAdd;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("reset_outs", 64'(outs()), 64'd0);
    check("reset_rdy", 64'(InReady), 64'd1);

    // Back-to-back single-cycle ops
    single("add45", OpAdd, 32'd4, 32'd5, 32'd9, 4'b0000);
    single("sub45", OpSub, 32'd4, 32'd5, 32'hFFFF_FFFF, 4'b0100);
    single("and45", OpAnd, 32'd4, 32'd5, 32'd4, 4'b0000);
    single("orr45", OpOrr, 32'd4, 32'd5, 32'd5, 4'b0000);
    single("add_ovf", OpAdd, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0110);
    single("add_carry", OpAdd, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1001);
    single("sub_eq", OpSub, 32'd5, 32'd5, 32'd0, 4'b1001);
    single("sub_ovf", OpSub, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011);
    single("eor", OpEor, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000);
    single("lsl1", OpLsl, 32'h8000_0001, 32'd1, 32'd2, 4'b0001);
    single("lsr0", OpLsr, 32'd1, 32'd0, 32'd1, 4'b0000);
    single("lsr1", OpLsr, 32'd3, 32'h0000_0021, 32'd1, 4'b0001);
    InValid = 1'b0;
    @(posedge clk); #1;
    check("drain_idle", 64'(OutValid), 64'd0);

    // Backpressure: result held, InReady low, then pop and load on the same edge
    OutReady = 1'b0;
    single("bp_add", OpAdd, 32'd11, 32'd22, 32'd33, 4'b0000);
    ALUControl = OpEor; SrcA = 32'hFF; SrcB = 32'h0F; InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", 64'(outs()), 64'({1'b1, 32'd33, 4'b0000}));
      check("bp_rdy", 64'(InReady), 64'd0);
    end
    OutReady = 1'b1;
    #1;
    check("bp_release_rdy", 64'(InReady), 64'd1);
    @(posedge clk); #1;
    check("bp_swap", 64'(outs()), 64'({1'b1, 32'h0000_00F0, 4'b0000}));
    InValid = 1'b0;
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    // MUL latency and busy InReady; operands scrambled after acceptance
    ALUControl = OpMul; SrcA = 32'd6; SrcB = 32'd7; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678; ALUControl = OpAdd;
    n = 0; ok = 1'b1;
    while (!OutValid && n < 100) begin
      if (InReady) ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check("mul_latency", 64'(n), 64'(W + 2));
    check("mul_busy_rdy", 64'(ok), 64'd1);
    check("mul_6x7", 64'(outs()), 64'({1'b1, 32'd42, 4'b0000}));
    @(posedge clk); #1;

    ALUControl = OpMul; SrcA = 32'h0001_0000; SrcB = 32'h0001_0000; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    n = 0;
    while (!OutValid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mul_big", 64'(outs()), 64'({1'b1, 32'd0, 4'b1010}));
    @(posedge clk); #1;
`else
    single("mul_off", OpMul, 32'd6, 32'd7, 32'd0, 4'b1000);
    InValid = 1'b0;
    @(posedge clk); #1;
`endif

    // Randomized run against the scoreboard, with random backpressure
    for (int i = 0; i < 400; i++) begin
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      ALUControl = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: SrcA = 32'h8000_0000;
        1: SrcA = 32'hFFFF_FFFF;
        2: SrcA = 32'($urandom_range(0, 15));
        default: SrcA = $urandom;
      endcase
      SrcB = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      #1;
      acc = InValid && InReady;
      pop = OutValid && OutReady;
      if (pop) begin
        check("rnd_nonempty", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          check($sformatf("rnd_%0d", i), 64'({ALUResult, Zero, Negative, Overflow, Carry}),
                64'(q.pop_front()));
        end
      end
      if (acc) q.push_back(model(ALUControl, SrcA, SrcB));
      @(posedge clk); #1;
    end
    InValid = 1'b0; OutReady = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      #1;
      if (OutValid) begin
        check("drain", 64'({ALUResult, Zero, Negative, Overflow, Carry}), 64'(q.pop_front()));
      end
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    check("drain_valid", 64'(OutValid), 64'd0);

    // Reset in the middle of a busy period
    ALUControl = OpMul; SrcA = 32'd9; SrcB = 32'd9; InValid = 1'b1; OutReady = 1'b0;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    OutReady = 1'b1;
    #1;
    check("rst_mid_outs", 64'(outs()), 64'd0);
    check("rst_mid_rdy", 64'(InReady), 64'd1);
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (OutValid) ok = 1'b0;
    end
    check("rst_no_result", 64'(ok), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
